// File: rtl/serialboot_pkg.sv
// ============================================================================
// Module   : serialboot_pkg
// Purpose  : Shared FSM state type, control register map and ASCII hex decode
//            for the serial boot hex loader.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package serialboot_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_FLUSH = 2'd2
   } sb_state_t;

   localparam logic [2:0] c_reg_status = 3'd0;
   localparam logic [2:0] c_reg_addr   = 3'd1;
   localparam logic [2:0] c_reg_ctrl   = 3'd2;
   localparam logic [2:0] c_reg_count  = 3'd3;
   localparam logic [2:0] c_reg_csum   = 3'd4;

   // Returns {valid, nibble}; valid is 0 for any non-hex character.
   function automatic logic [4:0] hex_decode(input logic [7:0] ch);
      logic [4:0] res;
      res = 5'b0;
      if (ch >= 8'h30 && ch <= 8'h39) begin
         res = {1'b1, 4'(ch - 8'h30)};
      end else if (ch >= 8'h61 && ch <= 8'h66) begin
         res = {1'b1, 4'(ch - 8'h57)};
      end else if (ch >= 8'h41 && ch <= 8'h46) begin
         res = {1'b1, 4'(ch - 8'h37)};
      end
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sb_word_fifo.sv
// ============================================================================
// Module   : sb_word_fifo
// Purpose  : Synchronous word FIFO with full/empty flags, simultaneous push and
//            pop (also when full) and a synchronous clear.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sb_word_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W:0]   r_wr_ptr;
   logic [PTR_W:0]   r_rd_ptr;
   logic             w_wr_en;
   logic             w_rd_en;

   assign empty   = (r_wr_ptr == r_rd_ptr);
   assign full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign w_rd_en = pop & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_wr_en = push & (~full | w_rd_en);
   assign dout    = r_mem[r_rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en && !clr) r_mem[r_wr_ptr[PTR_W-1:0]] <= din;
   end

endmodule

`default_nettype wire

// File: rtl/serialboot_fifo.sv
// ============================================================================
// Module   : serialboot_fifo
// Purpose  : UART hex loader: assembles hex digits into words, buffers them and
//            writes them to memory with a ready handshake, overriding the CPU
//            memory bus while loading. SERIALBOOT_CHECKSUM_EN adds a word sum.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serialboot_fifo
   import serialboot_pkg::*;
#(
   parameter int         WORD_W     = 32,
   parameter int         ADDR_W     = 32,
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] END_CHAR   = 8'h20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        a,
   input  logic [31:0]       d,
   input  logic              we,
   output logic [31:0]       spo,
   output logic              ready,
   input  logic              burst_en_cpu,
   input  logic [7:0]        burst_length_cpu,
   input  logic [ADDR_W-1:0] a_cpu,
   input  logic [WORD_W-1:0] d_cpu,
   input  logic              we_cpu,
   input  logic              rd_cpu,
   output logic [WORD_W-1:0] spo_cpu,
   output logic              ready_cpu,
   output logic              burst_en_mem,
   output logic [7:0]        burst_length_mem,
   output logic [ADDR_W-1:0] a_mem,
   output logic [WORD_W-1:0] d_mem,
   output logic              we_mem,
   output logic              rd_mem,
   input  logic [WORD_W-1:0] spo_mem,
   input  logic              ready_mem,
   input  logic [7:0]        uart_data,
   input  logic              uart_ready
);

   localparam int ND    = WORD_W / 4;
   localparam int CNT_W = $clog2(ND);
   localparam logic [CNT_W-1:0]  c_last      = CNT_W'(ND - 1);
   localparam logic [ADDR_W-1:0] c_addr_step = ADDR_W'(WORD_W / 8);

   sb_state_t         r_state;
   sb_state_t         w_state_nxt;
   logic              r_abort;
   logic              w_abort_nxt;
   logic [ADDR_W-1:0] r_start_addr;
   logic [ADDR_W-1:0] r_cur_addr;
   logic [31:0]       r_count;
   logic              r_ovf;
   logic              r_pad;
   logic [CNT_W-1:0]  r_cnt;
   logic [WORD_W-1:0] r_word;
   logic [WORD_W-1:0] w_word_ins;
   logic [WORD_W-1:0] w_push_data;
   logic [WORD_W-1:0] w_head;
   logic [ADDR_W-1:0] w_d_addr;
   logic [31:0]       w_cur32;
   logic [31:0]       w_csum;
   logic [4:0]        w_dec;
   logic              w_busy;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_clr;
   logic              w_digit;
   logic              w_end;
   logic              w_wr_req;
   logic              w_fire;
   logic              w_start_cmd;
   logic              w_start_go;
   logic              w_abort_cmd;

   assign w_dec       = hex_decode(uart_data);
   assign w_busy      = (r_state != ST_IDLE);
   assign w_wr_req    = w_busy & ~w_empty;
   assign w_fire      = w_wr_req & ready_mem;
   assign w_start_cmd = we & (a == c_reg_ctrl) & d[0];
   assign w_start_go  = w_start_cmd & (r_state == ST_IDLE);
   assign w_abort_cmd = we & (a == c_reg_ctrl) & ~d[0] & w_busy;
   assign ready       = ~w_busy & ~we;

   generate
      if (ADDR_W >= 32) begin : g_addr_wide
         assign w_d_addr = ADDR_W'(d);
         assign w_cur32  = r_cur_addr[31:0];
      end else begin : g_addr_narrow
         assign w_d_addr = d[ADDR_W-1:0];
         assign w_cur32  = 32'(r_cur_addr);
      end
   endgenerate

   // Word being assembled with the incoming nibble placed at the counter slot.
   always_comb begin
      w_word_ins = r_word;
      for (int i = 0; i < ND; i++) begin
         if (r_cnt == CNT_W'(ND - 1 - i)) w_word_ins[i*4 +: 4] = w_dec[3:0];
      end
   end

   sb_word_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_clr),
      .push  (w_push),
      .pop   (w_fire),
      .din   (w_push_data),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_abort <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_abort <= w_abort_nxt;
      end
   end

   // An abort keeps only the write already on the bus; once it completes
   // (or if none is pending) the buffer is cleared and the loader idles.
   always_comb begin
      w_state_nxt = r_state;
      w_abort_nxt = r_abort;
      w_push      = 1'b0;
      w_push_data = r_word;
      w_clr       = 1'b0;
      w_digit     = 1'b0;
      w_end       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start_cmd) begin
               w_state_nxt = ST_RECV;
               w_abort_nxt = 1'b0;
            end
         end
         ST_RECV: begin
            if (w_abort_cmd) begin
               if (w_fire || w_empty) begin
                  w_clr       = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_abort_nxt = 1'b1;
                  w_state_nxt = ST_FLUSH;
               end
            end else if (uart_ready) begin
               if (uart_data == END_CHAR) begin
                  w_end       = 1'b1;
                  w_push      = (r_cnt != '0);
                  w_state_nxt = ST_FLUSH;
               end else if (w_dec[4]) begin
                  w_digit = 1'b1;
                  if (r_cnt == c_last) begin
                     w_push      = 1'b1;
                     w_push_data = w_word_ins;
                  end
               end
            end
         end
         ST_FLUSH: begin
            if (r_abort || w_abort_cmd) begin
               if (w_fire || w_empty) begin
                  w_clr       = 1'b1;
                  w_abort_nxt = 1'b0;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_abort_nxt = 1'b1;
               end
            end else if (w_empty) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_abort_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_start_addr <= '0;
         r_cur_addr   <= '0;
         r_count      <= '0;
         r_ovf        <= 1'b0;
         r_pad        <= 1'b0;
         r_cnt        <= '0;
         r_word       <= '0;
      end else begin
         if (we && (a == c_reg_addr) && !w_busy) r_start_addr <= w_d_addr;
         if (w_start_go) begin
            r_cur_addr <= r_start_addr;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_pad      <= 1'b0;
            r_cnt      <= '0;
            r_word     <= '0;
         end else begin
            if (w_fire) begin
               r_cur_addr <= r_cur_addr + c_addr_step;
               r_count    <= r_count + 32'd1;
            end
            if (w_push && w_full && !w_fire) r_ovf <= 1'b1;
            if (w_end) begin
               if (r_cnt != '0) r_pad <= 1'b1;
               r_cnt  <= '0;
               r_word <= '0;
            end else if (w_digit) begin
               if (r_cnt == c_last) begin
                  r_cnt  <= '0;
                  r_word <= '0;
               end else begin
                  r_cnt  <= r_cnt + 1'b1;
                  r_word <= w_word_ins;
               end
            end else if (w_abort_cmd) begin
               r_cnt  <= '0;
               r_word <= '0;
            end
         end
      end
   end

`ifdef SERIALBOOT_CHECKSUM_EN
   logic [31:0] r_csum;
   logic [31:0] w_head32;

   if (WORD_W >= 32) begin : g_csum_trunc
      assign w_head32 = w_head[31:0];
   end else begin : g_csum_ext
      assign w_head32 = 32'(w_head);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_csum <= '0;
      end else if (w_start_go) begin
         r_csum <= '0;
      end else if (w_fire) begin
         r_csum <= r_csum + w_head32;
      end
   end

   assign w_csum = r_csum;
`else
   assign w_csum = 32'h0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spo <= '0;
      end else begin
         case (a)
            c_reg_status: spo <= {29'b0, r_ovf, r_pad, w_busy};
            c_reg_addr:   spo <= w_cur32;
            c_reg_count:  spo <= r_count;
            c_reg_csum:   spo <= w_csum;
            default:      spo <= '0;
         endcase
      end
   end

   always_comb begin
      burst_en_mem     = burst_en_cpu;
      burst_length_mem = burst_length_cpu;
      a_mem            = a_cpu;
      d_mem            = d_cpu;
      we_mem           = we_cpu;
      rd_mem           = rd_cpu;
      ready_cpu        = ready_mem;
      spo_cpu          = spo_mem;
      if (w_busy) begin
         burst_en_mem     = 1'b0;
         burst_length_mem = 8'd0;
         a_mem            = r_cur_addr;
         d_mem            = w_head;
         we_mem           = w_wr_req;
         rd_mem           = 1'b0;
         ready_cpu        = 1'b0;
      end
   end

endmodule

`default_nettype wire
